cdc_sample_sender: RTL and testbench

- Source-domain stage directly upstream of the flag/ack clock-domain crossing in the SSB transmitter.
- Accepts audio/IQ sample strobes in the source clock domain and buffers them in a small FIFO.
- Presents one sample at a time on a held-stable data bus, pulses the crossing's flag input, and waits for the crossing's busy to drop before sending the next sample.
- The destination domain samples xfer_data when its flag output fires; this block guarantees the data is stable for the whole transfer.

---
 rtl/cdc_sample_sender_if.sv | 25 ++
 rtl/cdc_sample_sender.sv | 114 +++++++++++
 tb/tb_cdc_sample_sender.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_sample_sender_if.sv
// Bundle between the sample source, cdc_sample_sender and the flag/ack crossing.
// The master modport is the sender's view; the slave modport is its environment.
interface cdc_sample_sender_if #(
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 2
);
   logic [DATA_W-1:0]   in_data;
   logic                in_valid;
   logic [DATA_W-1:0]   xfer_data;
   logic                xfer_flag;
   logic                xfer_busy;
   logic [DEPTH_LOG2:0] fifo_level;
   logic                ovf_sticky;
   logic [7:0]          ovf_count;

   modport master (
      input  in_data, in_valid, xfer_busy,
      output xfer_data, xfer_flag, fifo_level, ovf_sticky, ovf_count
   );

   modport slave (
      output in_data, in_valid, xfer_busy,
      input  xfer_data, xfer_flag, fifo_level, ovf_sticky, ovf_count
   );
endinterface

// File: rtl/cdc_sample_sender.sv
// Source-domain sample FIFO feeding a flag/ack crossing one word at a time.
// Define CDC_SAMPLE_SENDER_OVF_CNT_EN to build the saturating dropped-sample counter.
module cdc_sample_sender #(
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 2
) (
   input logic                    clk,
   input logic                    rst,
   cdc_sample_sender_if.master    bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PTR_W = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {IDLE, ARM, WAIT_ACK} state_t;

   state_t            state_q;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0]  level_q, level_d;
   logic [DATA_W-1:0] xferData_q;
   logic              xferFlag_q;
   logic              ovfSticky_q;
   logic [PTR_W-1:0]  occupancy;
   logic              empty, full, pop, push, drop;

   // A pop in the same cycle frees a slot, so a strobe on a full FIFO is still taken.
   assign occupancy = wrPtr_q - rdPtr_q;
   assign empty     = (occupancy == '0);
   assign full      = (occupancy == PTR_W'(DEPTH));
   assign pop       = (state_q == IDLE) && !empty;
   assign push      = bus.in_valid && (!full || pop);
   assign drop      = bus.in_valid && full && !pop;
   assign wrPtr_d   = wrPtr_q + PTR_W'(push);
   assign rdPtr_d   = rdPtr_q + PTR_W'(pop);
   assign level_d   = wrPtr_d - rdPtr_d;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q[DEPTH_LOG2-1:0]] <= bus.in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         level_q     <= '0;
         ovfSticky_q <= 1'b0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         level_q <= level_d;
         if (drop) begin
            ovfSticky_q <= 1'b1;
         end
      end
   end

   // ARM also absorbs a busy left over from a transfer cut short by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         xferData_q <= '0;
         xferFlag_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  xferData_q <= mem_q[rdPtr_q[DEPTH_LOG2-1:0]];
                  xferFlag_q <= 1'b1;
                  state_q    <= ARM;
               end
            end
            ARM: begin
               if (!bus.xfer_busy) begin
                  xferFlag_q <= 1'b0;
                  state_q    <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (!bus.xfer_busy) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               xferFlag_q <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

`ifdef CDC_SAMPLE_SENDER_OVF_CNT_EN
   logic [7:0] ovfCount_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovfCount_q <= 8'd0;
      end else if (drop && (ovfCount_q != 8'hFF)) begin
         ovfCount_q <= ovfCount_q + 8'd1;
      end
   end

   assign bus.ovf_count = ovfCount_q;
`else
   assign bus.ovf_count = 8'd0;
`endif

   assign bus.xfer_data  = xferData_q;
   assign bus.xfer_flag  = xferFlag_q;
   assign bus.fifo_level = level_q;
   assign bus.ovf_sticky = ovfSticky_q;
endmodule

// File: tb/tb_cdc_sample_sender.sv
// Bench for cdc_sample_sender: constant vector table, scripted corner cases and a
// randomized run, all compared against a queue-based model of the sender.
module tb_cdc_sample_sender;
   localparam int DATA_W     = 16;
   localparam int DEPTH_LOG2 = 2;
   localparam int DEPTH      = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   cdc_sample_sender_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

   cdc_sample_sender #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Model: pending samples, the word last handed to the crossing, and the
   // transfer phase (0 = free, 1 = flag raised, 2 = accepted, waiting for release).
   logic [15:0] mq[$];
   int          phase;
   logic [15:0] mData;
   bit          mSticky;
   int          mDrops;

   int          busyLeft;
   int          busyLen;
   logic [15:0] delivered[$];
   int          peakLevel;

   typedef struct {
      bit          v;
      logic [15:0] d;
      bit          b;
      bit          eFlag;
      logic [15:0] eData;
      int          eLevel;
   } vec_t;

   vec_t table1[11];

   function automatic int expCount();
`ifdef CDC_SAMPLE_SENDER_OVF_CNT_EN
      return (mDrops > 255) ? 255 : mDrops;
`else
      return 0;
`endif
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mq.delete();
      phase   = 0;
      mData   = '0;
      mSticky = 1'b0;
      mDrops  = 0;
   endtask

   // One clock edge of the sender: hand off the head if free, then take the strobe.
   task automatic modelEdge(input bit v, input logic [15:0] d, input bit b);
      if (phase == 0) begin
         if (mq.size() > 0) begin
            mData = mq.pop_front();
            phase = 1;
         end
      end else if (phase == 1) begin
         if (!b) phase = 2;
      end else begin
         if (!b) phase = 0;
      end
      if (v) begin
         if (mq.size() < DEPTH) begin
            mq.push_back(d);
         end else begin
            mSticky = 1'b1;
            mDrops++;
         end
      end
   endtask

   task automatic checkOutput();
      checkVal("xfer_flag",  {31'd0, bus.xfer_flag}, (phase == 1) ? 32'd1 : 32'd0);
      checkVal("xfer_data",  {16'd0, bus.xfer_data}, {16'd0, mData});
      checkVal("fifo_level", {29'd0, bus.fifo_level}, mq.size());
      checkVal("ovf_sticky", {31'd0, bus.ovf_sticky}, {31'd0, mSticky});
      checkVal("ovf_count",  {24'd0, bus.ovf_count}, expCount());
   endtask

   task automatic applyStimulus(input bit v, input logic [15:0] d, input bit b);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.xfer_busy = b;
      if (bus.xfer_flag && !b) delivered.push_back(bus.xfer_data);
      @(posedge clk);
      modelEdge(v, d, b);
      #1;
      if (int'(bus.fifo_level) > peakLevel) peakLevel = int'(bus.fifo_level);
      checkOutput();
   endtask

   // Drives busy like the crossing: high for busyLen cycles after each accept.
   task automatic autoStep(input bit v, input logic [15:0] d);
      bit b;
      bit accepting;
      b         = (busyLeft > 0);
      accepting = (phase == 1) && !b;
      applyStimulus(v, d, b);
      if (busyLeft > 0) busyLeft--;
      if (accepting) busyLeft = busyLen;
   endtask

   task automatic applyReset(input bit b);
      #2;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.xfer_busy = b;
      rst = 1'b1;
      #1;
      modelReset();
      checkOutput();
      @(posedge clk);
      #2;
      rst = 1'b0;
      busyLeft  = 0;
      peakLevel = 0;
      delivered.delete();
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.xfer_busy = 1'b0;
      modelReset();
      busyLen = 6;

      table1[0]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1};
      table1[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 0};
      table1[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 0};
      for (int i = 3; i < 9; i++) table1[i] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 0};
      table1[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 0};
      table1[10] = '{1'b1, 16'h5678, 1'b0, 1'b0, 16'h1234, 1};

      $display("[TB] single transfer table");
      applyReset(1'b0);
      for (int i = 0; i < 11; i++) begin
         applyStimulus(table1[i].v, table1[i].d, table1[i].b);
         checkVal($sformatf("tbl%0d_flag", i), {31'd0, bus.xfer_flag}, {31'd0, table1[i].eFlag});
         checkVal($sformatf("tbl%0d_data", i), {16'd0, bus.xfer_data}, {16'd0, table1[i].eData});
         checkVal($sformatf("tbl%0d_level", i), {29'd0, bus.fifo_level}, table1[i].eLevel);
      end
      applyStimulus(1'b0, 16'h0000, 1'b0);
      checkVal("tbl_next_pop", {16'd0, bus.xfer_data}, 32'h5678);

      $display("[TB] four strobes in order");
      applyReset(1'b0);
      busyLen = 10;
      for (int i = 1; i <= 4; i++) autoStep(1'b1, 16'(i));
      for (int i = 0; i < 60; i++) autoStep(1'b0, 16'h0000);
      checkVal("order_count", delivered.size(), 4);
      for (int i = 0; i < delivered.size() && i < 4; i++)
         checkVal($sformatf("order%0d", i), {16'd0, delivered[i]}, i + 1);
      checkVal("order_sticky", {31'd0, bus.ovf_sticky}, 0);
      checkVal("order_peak", peakLevel, 3);

      $display("[TB] overflow with busy stuck high");
      applyReset(1'b1);
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 16'h0011 + 16'(i), 1'b1);
      checkVal("ovf7_held", {16'd0, bus.xfer_data}, 32'h0011);
      checkVal("ovf7_level", {29'd0, bus.fifo_level}, 4);
      checkVal("ovf7_sticky", {31'd0, bus.ovf_sticky}, 1);
`ifdef CDC_SAMPLE_SENDER_OVF_CNT_EN
      checkVal("ovf7_count", {24'd0, bus.ovf_count}, 2);
`else
      checkVal("ovf7_count", {24'd0, bus.ovf_count}, 0);
`endif

      $display("[TB] strobe on pop from a full fifo");
      applyStimulus(1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b1);
      applyStimulus(1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b1, 16'h5555, 1'b0);
      checkVal("fullpop_level", {29'd0, bus.fifo_level}, 4);
      checkVal("fullpop_data", {16'd0, bus.xfer_data}, 32'h0012);
`ifdef CDC_SAMPLE_SENDER_OVF_CNT_EN
      checkVal("fullpop_count", {24'd0, bus.ovf_count}, 2);
`else
      checkVal("fullpop_count", {24'd0, bus.ovf_count}, 0);
`endif

      $display("[TB] reset during wait with stale busy");
      applyReset(1'b0);
      busyLen = 20;
      autoStep(1'b1, 16'hAAAA);
      autoStep(1'b0, 16'h0000);
      autoStep(1'b0, 16'h0000);
      autoStep(1'b0, 16'h0000);
      checkVal("pre_reset_busy", busyLeft > 0, 1);
      applyReset(1'b1);
      checkVal("reset_flag_low", {31'd0, bus.xfer_flag}, 0);
      applyStimulus(1'b1, 16'hBEEF, 1'b1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 16'h0000, 1'b1);
         checkVal("arm_hold_flag", {31'd0, bus.xfer_flag}, 1);
      end
      busyLen = 3;
      delivered.delete();
      for (int i = 0; i < 12; i++) autoStep(1'b0, 16'h0000);
      checkVal("beef_once", delivered.size(), 1);
      if (delivered.size() > 0) checkVal("beef_data", {16'd0, delivered[0]}, 32'hBEEF);

      $display("[TB] randomized traffic");
      applyReset(1'b0);
      for (int i = 0; i < 400; i++)
         applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 2) == 0);

      $display("[TB] counter saturation");
      applyReset(1'b1);
      for (int i = 0; i < 300; i++) applyStimulus(1'b1, 16'(i), 1'b1);
      checkVal("sat_sticky", {31'd0, bus.ovf_sticky}, 1);
`ifdef CDC_SAMPLE_SENDER_OVF_CNT_EN
      checkVal("sat_count", {24'd0, bus.ovf_count}, 255);
`else
      checkVal("sat_count", {24'd0, bus.ovf_count}, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
